// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit and the ALU decode stage:
// FSM state encodings, instruction field positions and the halt opcode default.
package instr_issue_unit_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int INSTR_W        = 32;

    // Instruction field offsets (shared with the ALU decoder)
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_W   = 16;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Extract the opcode field of an instruction word
    function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Bus bundle of the issue unit: instruction-memory read port plus the issue port
// toward the ALU. The issue unit is the master of both.
interface instr_issue_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              alu;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] issue_pc;

    modport master (
        output imem_en, imem_addr, alu, instruction, issue_pc,
        input  imem_rdata
    );

    modport slave (
        input  imem_en, imem_addr, alu, instruction, issue_pc,
        output imem_rdata
    );
endinterface

// File: rtl/instr_issue_unit_skid_buf.sv
// Output register plus one skid entry. A read that returns while the ALU is
// stalled parks in the skid entry; the skid word always issues before newer data.
// Flush drops the skid and the returning word; halt drops them and records the
// halt word address as issue_pc.
module issue_skid_buf
    import instr_issue_unit_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [31:0]       in_data_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              halt_i,
    output logic              cand_halt_o,
    output logic              skid_valid_o,
    output logic              out_valid_o,
    output logic [31:0]       out_data_o,
    output logic [ADDR_W-1:0] out_pc_o
);

    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_data_q,  skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q,    skid_pc_d;
    logic              out_valid_q,  out_valid_d;
    logic [31:0]       out_data_q,   out_data_d;
    logic [ADDR_W-1:0] out_pc_q,     out_pc_d;
    logic              cand_valid_s;
    logic [31:0]       cand_data_s;
    logic [ADDR_W-1:0] cand_pc_s;

    // Issue candidate: the skid word has priority over the word returning from imem
    always_comb begin
        cand_valid_s = skid_valid_q || in_valid_i;
        if (skid_valid_q) begin
            cand_data_s = skid_data_q;
            cand_pc_s   = skid_pc_q;
        end else begin
            cand_data_s = in_data_i;
            cand_pc_s   = in_pc_i;
        end
        cand_halt_o = cand_valid_s && (get_opcode(cand_data_s) == HALT_OPCODE);
    end

    // Next-state of skid entry and output register
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        if (flush_i) begin
            skid_valid_d = 1'b0;
        end else if (stall_i) begin
            if (in_valid_i) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
                skid_pc_d    = in_pc_i;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end else if (halt_i) begin
            skid_valid_d = 1'b0;
            out_pc_d     = cand_pc_s;
        end else if (cand_valid_s) begin
            out_valid_d = 1'b1;
            out_data_d  = cand_data_s;
            out_pc_d    = cand_pc_s;
            if (skid_valid_q && in_valid_i) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
                skid_pc_d    = in_pc_i;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else begin
            skid_valid_d = 1'b0;
        end
    end

    // Skid and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= 32'd0;
            skid_pc_q    <= {ADDR_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'd0;
            out_pc_q     <= {ADDR_W{1'b0}};
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
        end
    end

    assign skid_valid_o = skid_valid_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_pc_o     = out_pc_q;

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: fetches words from a synchronous imem and issues them
// in program order to the ALU, with stall back-pressure, PC redirect and halt.
// FSM and PC counter live here; buffering lives in issue_skid_buf.
module instr_issue_unit
    import instr_issue_unit_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
    parameter logic [5:0]        HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    instr_issue_unit_if.master   bus,
    output logic                 halted,
    output logic                 busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              run_s, flush_s, halt_s, fetch_en_s;
    logic              cand_halt_s, skid_valid_s;
    logic              out_valid_s;
    logic [31:0]       out_data_s;
    logic [ADDR_W-1:0] out_pc_s;

    // Control decode: flush, halt at the issue point, and fetch permission
    always_comb begin
        run_s   = (state_q == ST_RUN);
        flush_s = run_s && redirect_valid;
        if (run_s && !stall && !redirect_valid && cand_halt_s) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
        fetch_en_s = run_s && !stall && !redirect_valid && !halt_s && !skid_valid_s;
    end

    // FSM next state and PC update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (flush_s) begin
                    pc_d = redirect_pc;
                end else if (halt_s) begin
                    state_d = ST_HALTED;
                end else if (fetch_en_s) begin
                    pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // FSM state, PC and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= fetch_en_s;
            inflight_pc_q <= fetch_en_s ? pc_q : inflight_pc_q;
        end
    end

    issue_skid_buf #(
        .ADDR_W      (ADDR_W),
        .HALT_OPCODE (HALT_OPCODE)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (inflight_q),
        .in_data_i    (bus.imem_rdata),
        .in_pc_i      (inflight_pc_q),
        .stall_i      (stall),
        .flush_i      (flush_s),
        .halt_i       (halt_s),
        .cand_halt_o  (cand_halt_s),
        .skid_valid_o (skid_valid_s),
        .out_valid_o  (out_valid_s),
        .out_data_o   (out_data_s),
        .out_pc_o     (out_pc_s)
    );

    assign bus.imem_en     = fetch_en_s;
    assign bus.imem_addr   = fetch_en_s ? pc_q : {ADDR_W{1'b0}};
    assign bus.alu         = out_valid_s;
    assign bus.instruction = out_data_s;
    assign bus.issue_pc    = out_pc_s;
    assign halted          = (state_q == ST_HALTED);
    assign busy            = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Testbench for instr_issue_unit: imem model, scoreboard of expected issues
// (pc, word) in program order, and one task per scenario.
module tb_instr_issue_unit;

    localparam int         AW     = 10;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   word;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halted;
    logic          busy;

    logic [31:0]   mem [0:(1<<AW)-1];
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [31:0]   last_word;
    int            checks;
    int            failures;

    instr_issue_unit_if #(.ADDR_W(AW)) bus ();

    instr_issue_unit #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .halted         (halted),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory model: data one cycle after the request
    always @(posedge clk) begin
        if (bus.imem_en === 1'b1) bus.imem_rdata <= mem[bus.imem_addr];
    end

    // Scoreboard monitor: every issue must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.alu === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: issued pc=%h instr=%h, required no issue", bus.issue_pc, bus.instruction);
            end else begin
                mon_e = exp_q.pop_front();
                last_word = mon_e.word;
                if (bus.instruction !== mon_e.word || bus.issue_pc !== mon_e.pc) begin
                    failures++;
                    $display("FAIL sb_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             bus.issue_pc, bus.instruction, mon_e.pc, mon_e.word);
                end
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1234_0000 + 32'(i);
    endtask

    task automatic push_exp(input int pc);
        exp_t e;
        e.pc = AW'(pc);
        e.word = mem[pc];
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.alu, bus.instruction, bus.issue_pc} !== '0) begin
            failures++;
            $display("FAIL reset_issue: alu=%b instr=%h pc=%h, required all 0", bus.alu, bus.instruction, bus.issue_pc);
        end
        checks++;
        if ({bus.imem_en, bus.imem_addr, halted, busy} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: en=%b addr=%h halted=%b busy=%b, required all 0", bus.imem_en, bus.imem_addr, halted, busy);
        end
    endtask

    task automatic test_stream();
        do_reset();
        fill_mem();
        mem[4] = HALT_W;
        for (int k = 0; k < 4; k++) push_exp(k);
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch: en=%b addr=%h busy=%b, required 1 000 1", bus.imem_en, bus.imem_addr, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.alu !== 1'b0) begin
            failures++;
            $display("FAIL latency_e1: alu=%b, required 0", bus.alu);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.alu !== 1'b1 || bus.issue_pc !== AW'(k)) begin
                failures++;
                $display("FAIL stream_%0d: alu=%b pc=%h, required 1 %h", k, bus.alu, bus.issue_pc, AW'(k));
            end
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.alu !== 1'b0 || bus.issue_pc !== 10'h004 || bus.instruction !== mem[3]) begin
            failures++;
            $display("FAIL stream_halt: halted=%b busy=%b alu=%b pc=%h instr=%h, required 1 0 0 004 %h",
                     halted, busy, bus.alu, bus.issue_pc, bus.instruction, mem[3]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_missing: %0d words not issued, required 0", exp_q.size());
        end
    endtask

    task automatic wait_halt(input string name, input logic [AW-1:0] pc);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
        checks++;
        if (halted !== 1'b1 || bus.alu !== 1'b0 || bus.issue_pc !== pc || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_end: halted=%b alu=%b pc=%h pending=%0d, required 1 0 %h 0",
                     name, halted, bus.alu, bus.issue_pc, exp_q.size(), pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        fill_mem();
        mem[2] = HALT_W;
        push_exp(0); push_exp(1);
        pulse_start();
        wait_halt("halt", 10'h002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.alu !== 1'b0 || halted !== 1'b1) begin
                failures++;
                $display("FAIL halt_hold_%0d: alu=%b halted=%b, required 0 1", i, bus.alu, halted);
            end
        end
        push_exp(0); push_exp(1);
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000) begin
            failures++;
            $display("FAIL restart: busy=%b halted=%b en=%b addr=%h, required 1 0 1 000", busy, halted, bus.imem_en, bus.imem_addr);
        end
        wait_halt("rehalt", 10'h002);
    endtask

    task automatic test_stall();
        do_reset();
        fill_mem();
        mem[10] = HALT_W;
        for (int k = 0; k < 10; k++) push_exp(k);
        pulse_start();
        repeat (5) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.alu !== 1'b0 || bus.imem_en !== 1'b0 || bus.instruction !== last_word) begin
                failures++;
                $display("FAIL stall_%0d: alu=%b en=%b instr=%h, required 0 0 %h", i, bus.alu, bus.imem_en, bus.instruction, last_word);
            end
        end
        stall = 1'b0;
        wait_halt("stall", 10'h00A);
    endtask

    task automatic wait_fetch(input logic [AW-1:0] addr, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.imem_en === 1'b1 && bus.imem_addr === addr) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_wait: fetch of %h not seen, required within 40 cycles", name, addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fill_mem();
        mem[10'h044] = HALT_W;
        for (int k = 0; k < 4; k++) push_exp(k);
        for (int k = 'h40; k < 'h44; k++) push_exp(k);
        pulse_start();
        wait_fetch(10'h005, "redir");
        redirect_valid = 1'b1; redirect_pc = 10'h040;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h040) begin
            failures++;
            $display("FAIL redir_fetch: alu=%b en=%b addr=%h, required 0 1 040", bus.alu, bus.imem_en, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.alu !== 1'b0) begin
            failures++;
            $display("FAIL redir_gap: alu=%b, required 0", bus.alu);
        end
        @(negedge clk);
        checks++;
        if (bus.alu !== 1'b1 || bus.issue_pc !== 10'h040) begin
            failures++;
            $display("FAIL redir_issue: alu=%b pc=%h, required 1 040", bus.alu, bus.issue_pc);
        end
        wait_halt("redir", 10'h044);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        fill_mem();
        mem[10'h082] = HALT_W;
        push_exp(0); push_exp(1); push_exp('h80); push_exp('h81);
        pulse_start();
        wait_fetch(10'h003, "rstall");
        redirect_valid = 1'b1; redirect_pc = 10'h080; stall = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_en !== 1'b0 || bus.alu !== 1'b0) begin
                failures++;
                $display("FAIL rstall_hold_%0d: en=%b alu=%b, required 0 0", i, bus.imem_en, bus.alu);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h080) begin
            failures++;
            $display("FAIL rstall_fetch: en=%b addr=%h, required 1 080", bus.imem_en, bus.imem_addr);
        end
        wait_halt("rstall", 10'h082);
    endtask

    task automatic test_wrap();
        do_reset();
        fill_mem();
        mem[1] = HALT_W;
        push_exp('h3FF); push_exp(0);
        pulse_start();
        redirect_valid = 1'b1; redirect_pc = 10'h3FF;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h3FF) begin
            failures++;
            $display("FAIL wrap_top: en=%b addr=%h, required 1 3ff", bus.imem_en, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000) begin
            failures++;
            $display("FAIL wrap_zero: en=%b addr=%h, required 1 000", bus.imem_en, bus.imem_addr);
        end
        wait_halt("wrap", 10'h001);
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_mem();
        mem[20] = HALT_W;
        for (int k = 0; k < 20; k++) push_exp(k);
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.alu !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: alu=%b, required 1", bus.alu);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({bus.alu, bus.instruction, bus.issue_pc, bus.imem_en, bus.imem_addr, halted, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset: alu=%b instr=%h pc=%h en=%b addr=%h halted=%b busy=%b, required all 0",
                     bus.alu, bus.instruction, bus.issue_pc, bus.imem_en, bus.imem_addr, halted, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.imem_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: busy=%b en=%b, required 0 0", busy, bus.imem_en);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_word = 32'd0;
        test_reset();
        test_stream();
        test_halt();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
